// File: rtl/conv45_window_scheduler.sv
// Raster read scheduler for a 5x5 convolution window: issues BRAM reads, tags window-valid
// pixels through a 1+CONV_LAT shift pipeline, and applies output backpressure. Optional: CONV45_FRAME_CNT_EN.
module conv45_window_scheduler #(
    parameter int IMG_WIDTH   = 516,
    parameter int IMG_HEIGHT  = 516,
    parameter int kernel_size = 5,
    parameter int ADDR_WIDTH  = 19,
    parameter int CONV_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  pipe_ce,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_row,
    output logic [15:0]           out_col
`ifdef CONV45_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    localparam int          DEPTH    = 1 + CONV_LAT;
    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] WIN_MIN  = 16'(kernel_size - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             row_q, row_d, col_q, col_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [15:0]             prow_q [DEPTH];
    logic [15:0]             prow_d [DEPTH];
    logic [15:0]             pcol_q [DEPTH];
    logic [15:0]             pcol_d [DEPTH];
    logic                    stall, adv, issue;
    logic [DEPTH-1:0]        vld_upstream;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        vld_d        = vld_q;
        prow_d       = prow_q;
        pcol_d       = pcol_q;
        issue        = 1'b0;
        stall        = vld_q[DEPTH-1] & ~out_ready;
        adv          = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !stall;
        vld_upstream = vld_q;
        vld_upstream[DEPTH-1] = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (adv) begin
                    issue = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d  = row_q + 16'd1;
                            addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        col_d  = col_q + 16'd1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the shift about to happen empties every valid tag
                if (adv && (vld_upstream == '0)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            vld_d[0]  = issue && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
            prow_d[0] = row_q;
            pcol_d[0] = col_q;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i]  = vld_q[i-1];
                prow_d[i] = prow_q[i-1];
                pcol_d[i] = pcol_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                prow_q[i] <= '0;
                pcol_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign bram_en   = issue;
    assign bram_addr = addr_q;
    assign pipe_ce   = adv;
    assign out_valid = vld_q[DEPTH-1];
    assign out_row   = prow_q[DEPTH-1];
    assign out_col   = pcol_q[DEPTH-1];

`ifdef CONV45_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (done && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_conv45_window_scheduler.sv
// Randomized-backpressure bench for conv45_window_scheduler on an 8x6 image; a frame-level
// model predicts the raster address stream, result coordinates and frame timing.
module tb_conv45_window_scheduler;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int KS   = 5;
    localparam int LAT  = 2;
    localparam int AW   = 19;
    localparam int NRD  = W * H;
    localparam int RPR  = W - KS + 1;
    localparam int NRES = RPR * (H - KS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, done, bram_en, pipe_ce, out_valid;
    logic [AW-1:0] bram_addr;
    logic [15:0]   out_row, out_col;
`ifdef CONV45_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    conv45_window_scheduler #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .kernel_size(KS), .ADDR_WIDTH(AW), .CONV_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .bram_en(bram_en), .bram_addr(bram_addr), .pipe_ce(pipe_ce),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col)
`ifdef CONV45_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // frame-level observation state
    int exp_addr, reads, res_cnt, busy_cyc, done_cnt, stall_cyc;
    int first_row, first_col, last_row, last_col, stall_row, stall_col;
    bit prev_stall;
    logic [15:0]   prev_row, prev_col;
    logic [AW-1:0] prev_addr;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_frame();
        exp_addr = 0; reads = 0; res_cnt = 0; busy_cyc = 0; done_cnt = 0; stall_cyc = 0;
        first_row = -1; first_col = -1; last_row = -1; last_col = -1;
        stall_row = -1; stall_col = -1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            bit stall_now;
            stall_now = out_valid && !out_ready;
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_row", out_row, prev_row);
                chk("stall_hold_col", out_col, prev_col);
                chk("stall_hold_addr", bram_addr, prev_addr);
            end
            chk("pipe_ce_rule", pipe_ce, busy && !stall_now);
            if (stall_now) begin
                chk("stall_no_read", bram_en, 0);
                if (stall_cyc == 0) begin stall_row = out_row; stall_col = out_col; end
                stall_cyc++;
            end
            if (bram_en) begin
                chk("read_addr", bram_addr, exp_addr);
                chk("read_in_bounds", bram_addr < NRD, 1);
                exp_addr++;
                reads++;
            end
            if (out_valid && out_ready) begin
                chk("res_row", out_row, KS - 1 + res_cnt / RPR);
                chk("res_col", out_col, KS - 1 + res_cnt % RPR);
                if (first_row < 0) begin first_row = out_row; first_col = out_col; end
                last_row = out_row; last_col = out_col;
                res_cnt++;
            end
            if (busy) busy_cyc++;
            if (done) begin
                chk("done_not_busy", busy, 0);
                done_cnt++;
            end
            prev_stall = stall_now;
            prev_row   = out_row;
            prev_col   = out_col;
            prev_addr  = bram_addr;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bram_en"}, bram_en, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_pipe_ce"}, pipe_ce, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_row"}, out_row, 0);
        chk({tag, "_out_col"}, out_col, 0);
    endtask

    // mode 0: always ready; 1: hold ready low 5 cycles on first valid; 2: random ready
    task automatic run_frame(input int mode, input int rst_addr, input bit mid_start);
        int stall_left;
        int tail;
        bit finished;
        stall_left = 5;
        tail = 0;
        finished = 0;
        begin_frame();
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            case (mode)
                1: begin
                    if (out_valid && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
                    else out_ready = 1'b1;
                end
                2: out_ready = ($urandom % 2) == 1;
                default: out_ready = 1'b1;
            endcase
            start = mid_start && (reads == 10);
            if (rst_addr >= 0 && bram_en && bram_addr == AW'(rst_addr)) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_vals("mid_rst");
                rst = 1'b0;
                chk("mid_rst_no_done", done_cnt, 0);
                finished = 1;
                break;
            end
            if (done_cnt > 0) begin
                tail++;
                if (tail > 3) begin finished = 1; break; end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!finished) chk("frame_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_reads"}, reads, NRD);
        chk({tag, "_results"}, res_cnt, NRES);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_busy_cycles"}, busy_cyc, NRD + LAT + 1 + stall_cyc);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // nominal frame: literal pins on the model
        run_frame(0, -1, 1'b0);
        check_frame("nominal");
        chk("nominal_busy_literal", busy_cyc, 51);
        chk("nominal_first_row", first_row, 4);
        chk("nominal_first_col", first_col, 4);
        chk("nominal_last_row", last_row, 5);
        chk("nominal_last_col", last_col, 7);

        // 5-cycle stall on the first result
        run_frame(1, -1, 1'b0);
        check_frame("stall5");
        chk("stall5_cycles", stall_cyc, 5);
        chk("stall5_row", stall_row, 4);
        chk("stall5_col", stall_col, 4);

        // random backpressure
        for (int k = 0; k < 3; k++) begin
            run_frame(2, -1, 1'b0);
            check_frame("random");
        end

        // reset abandoned mid-frame, then a clean frame
        run_frame(0, 20, 1'b0);
        run_frame(0, -1, 1'b0);
        check_frame("after_rst");

        // start pulsed during RUN is ignored
        run_frame(0, -1, 1'b1);
        check_frame("mid_start");

`ifdef CONV45_FRAME_CNT_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("frame_cnt_reset", frame_cnt, 0);
        for (int k = 0; k < 3; k++) run_frame(0, -1, 1'b0);
        chk("frame_cnt_three", frame_cnt, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
